// File: rtl/cpu_fetch_unit.sv
// rtl/cpu_fetch_unit.sv - instruction fetch stage: PC, instruction/operand registers, memory handshake
module cpu_fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset_cycle,
  input  logic [7:0] state,
  input  logic       jump_en,
  input  logic [7:0] jump_addr,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  output logic [7:0] opcode,
  output logic [7:0] operand,
  output logic       operand_vld,
  output logic [7:0] pc,
  output logic       stall,
  output logic       halted,
  output logic       bus_error
);

  // Control state codes, kept in step with the sequencer's state encoding.
  localparam logic [7:0] STATE_FETCH_PC = 8'h01;
  localparam logic [7:0] STATE_NEXT     = 8'h0F;
  localparam logic [7:0] STATE_HALT     = 8'hFF;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ABORT = 2'd2
  } fsm_t;

  fsm_t       fsm, fsm_next;
  logic       slot;
  logic [7:0] wait_cnt;
  logic       launch;
  logic       capture;
  logic       timeout;

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) fsm <= IDLE;
    else             fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    launch   = 1'b0;
    capture  = 1'b0;
    timeout  = 1'b0;
    case (fsm)
      IDLE: begin
        if (state == STATE_FETCH_PC && !halted) begin
          launch   = 1'b1;
          fsm_next = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          capture  = 1'b1;
          fsm_next = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout  = 1'b1;
          fsm_next = ABORT;
        end
      end
      ABORT:   fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      pc          <= RESET_PC;
      opcode      <= 8'h00;
      operand     <= 8'h00;
      operand_vld <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= 8'h00;
      stall       <= 1'b0;
      halted      <= 1'b0;
      bus_error   <= 1'b0;
      slot        <= 1'b0;
      wait_cnt    <= 8'h00;
    end else begin
      if (launch) begin
        mem_addr <= pc;
        mem_req  <= 1'b1;
        stall    <= 1'b1;
        wait_cnt <= 8'h00;
      end

      if (fsm == REQ && !mem_ready && !timeout)
        wait_cnt <= wait_cnt + 8'd1;

      if (capture) begin
        mem_req <= 1'b0;
        stall   <= 1'b0;
        pc      <= pc + 8'd1;
        if (!slot) begin
          opcode      <= mem_rdata;
          slot        <= 1'b1;
          operand_vld <= 1'b0;
        end else begin
          operand     <= mem_rdata;
          operand_vld <= 1'b1;
        end
      end

      // Request is dropped on the edge the timeout is detected; ABORT re-asserts the same result.
      if (timeout || fsm == ABORT) begin
        mem_req   <= 1'b0;
        stall     <= 1'b0;
        bus_error <= 1'b1;
        opcode    <= 8'h00;
      end

      if (state == STATE_NEXT)
        slot <= 1'b0;

      if (jump_en)
        pc <= jump_addr;

      if (state == STATE_HALT)
        halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// tb/tb_cpu_fetch_unit.sv - scoreboard bench for cpu_fetch_unit
module tb_cpu_fetch_unit;

  localparam logic [7:0] ST_IDLE  = 8'h00;
  localparam logic [7:0] ST_FETCH = 8'h01;
  localparam logic [7:0] ST_NEXT  = 8'h0F;
  localparam logic [7:0] ST_HALT  = 8'hFF;

  logic       clk = 1'b0;
  logic       reset_cycle;
  logic [7:0] state;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       operand_vld;
  logic [7:0] pc;
  logic       stall;
  logic       halted;
  logic       bus_error;

  cpu_fetch_unit #(.RESET_PC(8'h00), .MAX_WAIT(15)) dut (
    .clk(clk), .reset_cycle(reset_cycle), .state(state), .jump_en(jump_en),
    .jump_addr(jump_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .opcode(opcode), .operand(operand),
    .operand_vld(operand_vld), .pc(pc), .stall(stall), .halted(halted),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [7:0] opnd;
    logic       vld;
    logic [7:0] pc;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  logic [7:0] m_pc, m_op, m_opnd;
  logic       m_vld, m_slot;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_op = 8'h00; m_opnd = 8'h00; m_vld = 1'b0; m_slot = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_cycle = 1'b1;
    @(negedge clk);
    reset_cycle = 1'b0;
    model_reset();
  endtask

  task automatic pulse_state(input logic [7:0] code);
    @(negedge clk);
    state = code;
    @(negedge clk);
    state = ST_IDLE;
    if (code == ST_NEXT) m_slot = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [7:0] rdata, input int waits,
                       input logic jmp, input logic [7:0] jaddr);
    exp_t e;
    int   stall_cnt;
    @(negedge clk);
    state = ST_FETCH;
    @(negedge clk);
    state = ST_IDLE;
    check({tag, ".req"}, 8'(mem_req), 8'h01);
    check({tag, ".addr"}, mem_addr, m_pc);
    stall_cnt = stall ? 1 : 0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    jump_en   = jmp;
    jump_addr = jaddr;
    if (!m_slot) begin
      m_op = rdata; m_slot = 1'b1; m_vld = 1'b0;
    end else begin
      m_opnd = rdata; m_vld = 1'b1;
    end
    m_pc = jmp ? jaddr : m_pc + 8'd1;
    e.op = m_op; e.opnd = m_opnd; e.vld = m_vld; e.pc = m_pc;
    exp_q.push_back(e);
    @(negedge clk);
    mem_ready = 1'b0;
    jump_en   = 1'b0;
    e = exp_q.pop_front();
    check({tag, ".opcode"}, opcode, e.op);
    check({tag, ".operand"}, operand, e.opnd);
    check({tag, ".vld"}, 8'(operand_vld), 8'(e.vld));
    check({tag, ".pc"}, pc, e.pc);
    check({tag, ".stall_cycles"}, 8'(stall_cnt), 8'(waits + 1));
    check({tag, ".stall_end"}, 8'(stall), 8'h00);
    check({tag, ".req_end"}, 8'(mem_req), 8'h00);
  endtask

  initial begin
    int req_cnt;
    reset_cycle = 1'b1;
    state = ST_IDLE; jump_en = 1'b0; jump_addr = 8'h00;
    mem_rdata = 8'h00; mem_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    check("rst.pc", pc, 8'h00);
    check("rst.opcode", opcode, 8'h00);
    check("rst.req", 8'(mem_req), 8'h00);
    check("rst.stall", 8'(stall), 8'h00);
    check("rst.bus_error", 8'(bus_error), 8'h00);
    reset_cycle = 1'b0;

    // ready ignored while idle
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 8'hEE;
    @(negedge clk);
    mem_ready = 1'b0;
    check("idle_ready.opcode", opcode, 8'h00);
    check("idle_ready.pc", pc, 8'h00);

    fetch("zw", 8'h3C, 0, 1'b0, 8'h00);

    do_reset();
    fetch("two0", 8'h81, 3, 1'b0, 8'h00);
    fetch("two1", 8'h42, 3, 1'b0, 8'h00);

    // pc wrap, then jump winning over increment on a capture edge
    @(negedge clk);
    jump_en = 1'b1; jump_addr = 8'hFF;
    @(negedge clk);
    jump_en = 1'b0;
    m_pc = 8'hFF;
    check("jmp_idle.pc", pc, 8'hFF);
    pulse_state(ST_NEXT);
    fetch("wrap", 8'h11, 1, 1'b0, 8'h00);
    pulse_state(ST_NEXT);
    fetch("jcap", 8'h22, 2, 1'b1, 8'h20);

    // timeout: mem_ready never arrives
    @(negedge clk);
    state = ST_FETCH;
    @(negedge clk);
    state = ST_IDLE;
    req_cnt = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      req_cnt++;
      @(negedge clk);
    end
    check("to.req_cycles", 8'(req_cnt), 8'd15);
    @(negedge clk);
    check("to.req", 8'(mem_req), 8'h00);
    check("to.bus_error", 8'(bus_error), 8'h01);
    check("to.opcode", opcode, 8'h00);
    check("to.pc", pc, m_pc);
    check("to.stall", 8'(stall), 8'h00);

    // halt blocks new fetches
    pulse_state(ST_HALT);
    pulse_state(ST_FETCH);
    repeat (2) @(negedge clk);
    check("halt.halted", 8'(halted), 8'h01);
    check("halt.req", 8'(mem_req), 8'h00);
    check("halt.pc", pc, m_pc);

    // async reset in the middle of a request
    do_reset();
    check("rst2.halted", 8'(halted), 8'h00);
    @(negedge clk);
    state = ST_FETCH;
    @(negedge clk);
    state = ST_IDLE;
    check("mid.req_before", 8'(mem_req), 8'h01);
    #2 reset_cycle = 1'b1;
    #1;
    check("mid.req", 8'(mem_req), 8'h00);
    check("mid.stall", 8'(stall), 8'h00);
    check("mid.pc", pc, 8'h00);
    check("mid.addr", mem_addr, 8'h00);
    check("mid.bus_error", 8'(bus_error), 8'h00);
    @(negedge clk);
    reset_cycle = 1'b0;
    model_reset();
    fetch("after", 8'h5A, 0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
